// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick generator: each channel divides clk by a runtime-loadable
// period and emits a registered 1-cycle tick, periodic or one-shot, with per-channel pause.
module multi_tick_gen #(
    parameter int unsigned    CHANNELS       = 4,
    parameter int unsigned    W              = 26,
    parameter logic [W-1:0]   DEFAULT_PERIOD = W'(49_999_999),
    localparam int unsigned   CW             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                arst,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] mode,
    input  logic                load,
    input  logic [CW-1:0]       load_ch,
    input  logic [W-1:0]        load_period,
    input  logic [CW-1:0]       rd_ch,
    output logic [W-1:0]        rd_count,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] busy
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] DONE = 1'b1;

    logic [W-1:0]        period_q [CHANNELS];
    logic [W-1:0]        period_d [CHANNELS];
    logic [W-1:0]        q_q      [CHANNELS];
    logic [W-1:0]        q_d      [CHANNELS];
    logic [0:0]          state_q  [CHANNELS];
    logic [0:0]          state_d  [CHANNELS];
    logic [CHANNELS-1:0] tick_q;
    logic [CHANNELS-1:0] tick_d;
    logic [W-1:0]        rd_count_q;
    logic [W-1:0]        rd_count_d;
    logic [CHANNELS-1:0] load_hit;

    // An out-of-range load_ch simply matches no channel, so such loads are dropped.
    always_comb begin
        load_hit = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            load_hit[i] = load && (32'(load_ch) == i);
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        tick_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            period_d[i] = period_q[i];
            q_d[i]      = q_q[i];
            state_d[i]  = state_q[i];

            if (load_hit[i]) begin
                period_d[i] = load_period;
                q_d[i]      = '0;
                state_d[i]  = RUN;
            end else if (state_q[i] == DONE) begin
                // A finished one-shot re-arms only after its enable has been dropped once.
                q_d[i] = '0;
                if (!en[i]) begin
                    state_d[i] = RUN;
                end
            end else if (!en[i]) begin
                q_d[i] = q_q[i];
            end else if (q_q[i] == period_q[i]) begin
                q_d[i]    = '0;
                tick_d[i] = 1'b1;
                if (mode[i]) begin
                    state_d[i] = DONE;
                end
            end else begin
                q_d[i] = q_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        rd_count_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (32'(rd_ch) == i) begin
                rd_count_d = q_q[i];
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            busy[i] = en[i] && (state_q[i] == RUN);
        end
    end

    // NOTE: the per-channel arrays are working registers, not RAM, so they are all reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                period_q[i] <= DEFAULT_PERIOD;
                q_q[i]      <= '0;
                state_q[i]  <= RUN;
            end
            tick_q     <= '0;
            rd_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                period_q[i] <= period_d[i];
                q_q[i]      <= q_d[i];
                state_q[i]  <= state_d[i];
            end
            tick_q     <= tick_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign tick     = tick_q;
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_multi_tick_gen.sv
// Self-checking bench for multi_tick_gen: directed scenarios with fixed expectations, then
// randomized traffic against a phase/modulo reference model of each channel.
module tb_multi_tick_gen;

    localparam int unsigned CH   = 5;
    localparam int unsigned W    = 8;
    localparam int unsigned DEF  = 20;
    localparam int unsigned CW   = 3;

    logic          clk = 1'b0;
    logic          arst;
    logic [CH-1:0] en;
    logic [CH-1:0] mode;
    logic          load;
    logic [CW-1:0] load_ch;
    logic [W-1:0]  load_period;
    logic [CW-1:0] rd_ch;
    logic [W-1:0]  rd_count;
    logic [CH-1:0] tick;
    logic [CH-1:0] busy;

    int total = 0;
    int bad   = 0;

    // Reference model: enabled cycles elapsed since arming; ticks fall on multiples of period+1.
    int unsigned m_period [CH];
    int unsigned m_phase  [CH];
    bit          m_done   [CH];
    bit          m_tick   [CH];
    int unsigned m_rd;

    multi_tick_gen #(
        .CHANNELS(CH),
        .W(W),
        .DEFAULT_PERIOD(W'(DEF))
    ) dut (
        .clk(clk),
        .arst(arst),
        .en(en),
        .mode(mode),
        .load(load),
        .load_ch(load_ch),
        .load_period(load_period),
        .rd_ch(rd_ch),
        .rd_count(rd_count),
        .tick(tick),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int unsigned model_q(int unsigned ch);
        if (m_done[ch]) return 0;
        return m_phase[ch] % (m_period[ch] + 1);
    endfunction

    function automatic logic [CH-1:0] model_tick();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = m_tick[i];
        return v;
    endfunction

    function automatic logic [CH-1:0] model_busy();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = en[i] & ~m_done[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_period[i] = DEF;
            m_phase[i]  = 0;
            m_done[i]   = 1'b0;
            m_tick[i]   = 1'b0;
        end
        m_rd = 0;
    endtask

    task automatic model_edge();
        int unsigned rq;
        rq = (int'(rd_ch) < CH) ? model_q(int'(rd_ch)) : 0;
        for (int i = 0; i < CH; i++) begin
            m_tick[i] = 1'b0;
            if (load && int'(load_ch) == i) begin
                m_period[i] = load_period;
                m_phase[i]  = 0;
                m_done[i]   = 1'b0;
            end else if (m_done[i]) begin
                if (!en[i]) m_done[i] = 1'b0;
            end else if (en[i]) begin
                m_phase[i]++;
                if (m_phase[i] % (m_period[i] + 1) == 0) begin
                    m_tick[i] = 1'b1;
                    if (mode[i]) begin
                        m_done[i]  = 1'b1;
                        m_phase[i] = 0;
                    end
                end
            end
        end
        m_rd = rq;
    endtask

    task automatic tick_clk();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int ch, input int p);
        load        = 1'b1;
        load_ch     = CW'(ch);
        load_period = W'(p);
        tick_clk();
        load        = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1; en = '0; mode = '0; load = 1'b0;
        load_ch = '0; load_period = '0; rd_ch = '0;
        model_reset();
        #3;
        total++; if (tick !== '0) begin bad++; $display("FAIL reset_tick got=%b want=0", tick); end
        total++; if (rd_count !== '0) begin bad++; $display("FAIL reset_rd got=%0d want=0", rd_count); end
        @(negedge clk);
        arst = 1'b0;
        en = '1;
        #1;
        total++; if (busy !== 5'b11111) begin bad++; $display("FAIL reset_busy got=%b want=11111", busy); end
        en = '0;
        tick_clk();
    endtask

    task automatic test_periodic();
        en = 5'b00001; mode = '0;
        do_load(0, 3);
        for (int c = 1; c <= 12; c++) begin
            logic [CH-1:0] exp;
            tick_clk();
            exp = (c % 4 == 0) ? 5'b00001 : 5'b00000;
            total++;
            if (tick !== exp) begin bad++; $display("FAIL periodic c=%0d got=%b want=%b", c, tick, exp); end
        end
    endtask

    task automatic test_oneshot();
        en = 5'b00010; mode = 5'b00010;
        do_load(1, 2);
        for (int c = 1; c <= 6; c++) begin
            logic [CH-1:0] exp_t, exp_b;
            tick_clk();
            exp_t = (c == 3) ? 5'b00010 : 5'b00000;
            exp_b = (c >= 3) ? 5'b00000 : 5'b00010;
            total++;
            if (tick !== exp_t) begin bad++; $display("FAIL oneshot_tick c=%0d got=%b want=%b", c, tick, exp_t); end
            total++;
            if (busy !== exp_b) begin bad++; $display("FAIL oneshot_busy c=%0d got=%b want=%b", c, busy, exp_b); end
        end
        en = '0;
        tick_clk();
        en = 5'b00010;
        #1;
        total++; if (busy !== 5'b00010) begin bad++; $display("FAIL rearm_busy got=%b want=00010", busy); end
        for (int c = 1; c <= 5; c++) begin
            logic [CH-1:0] exp_t;
            tick_clk();
            exp_t = (c == 3) ? 5'b00010 : 5'b00000;
            total++;
            if (tick !== exp_t) begin bad++; $display("FAIL rearm_tick c=%0d got=%b want=%b", c, tick, exp_t); end
        end
        mode = '0;
    endtask

    task automatic test_pause();
        en = 5'b00100; mode = '0; rd_ch = 3'd2;
        do_load(2, 5);
        tick_clk();
        tick_clk();
        en = '0;
        for (int c = 1; c <= 10; c++) begin
            tick_clk();
            total++;
            if (rd_count !== 8'd2) begin bad++; $display("FAIL pause_rd c=%0d got=%0d want=2", c, rd_count); end
            total++;
            if (tick !== '0) begin bad++; $display("FAIL pause_tick c=%0d got=%b want=0", c, tick); end
        end
        en = 5'b00100;
        for (int c = 1; c <= 5; c++) begin
            logic [CH-1:0] exp;
            tick_clk();
            exp = (c == 4) ? 5'b00100 : 5'b00000;
            total++;
            if (tick !== exp) begin bad++; $display("FAIL resume c=%0d got=%b want=%b", c, tick, exp); end
        end
    endtask

    task automatic test_reload();
        en = 5'b00001; mode = '0;
        do_load(0, 3);
        tick_clk();
        tick_clk();
        do_load(0, 9);
        for (int c = 1; c <= 10; c++) begin
            logic [CH-1:0] exp;
            if (c == 3) begin load = 1'b1; load_ch = 3'd5; load_period = 8'd1; end
            if (c == 6) begin load = 1'b1; load_ch = 3'd7; load_period = 8'd0; end
            tick_clk();
            load = 1'b0;
            exp = (c == 10) ? 5'b00001 : 5'b00000;
            total++;
            if (tick !== exp) begin bad++; $display("FAIL reload c=%0d got=%b want=%b", c, tick, exp); end
        end
    endtask

    task automatic test_period0();
        en = 5'b01001; mode = '0;
        do_load(3, 0);
        do_load(0, 3);
        for (int c = 1; c <= 8; c++) begin
            logic [CH-1:0] exp;
            tick_clk();
            exp = (c % 4 == 0) ? 5'b01001 : 5'b01000;
            total++;
            if (tick !== exp) begin bad++; $display("FAIL period0 c=%0d got=%b want=%b", c, tick, exp); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            logic [CH-1:0] r;
            r    = CH'($urandom);
            en   = ($urandom_range(0, 9) < 8) ? CH'(r | CH'($urandom)) : r;
            mode = CH'($urandom) & CH'($urandom);
            load = ($urandom_range(0, 7) == 0);
            load_ch     = CW'($urandom_range(0, 7));
            load_period = W'($urandom_range(0, 7));
            rd_ch       = CW'($urandom_range(0, 7));
            tick_clk();
            total++;
            if (tick !== model_tick()) begin
                bad++; $display("FAIL rand_tick c=%0d got=%b want=%b", c, tick, model_tick());
            end
            total++;
            if (rd_count !== W'(m_rd)) begin
                bad++; $display("FAIL rand_rd c=%0d got=%0d want=%0d", c, rd_count, m_rd);
            end
            total++;
            if (busy !== model_busy()) begin
                bad++; $display("FAIL rand_busy c=%0d got=%b want=%b", c, busy, model_busy());
            end
        end
        load = 1'b0;
    endtask

    task automatic test_arst();
        en = '1; mode = '0; rd_ch = 3'd0;
        do_load(0, 200);
        for (int c = 0; c < 7; c++) tick_clk();
        arst = 1'b1;
        #2;
        total++; if (tick !== '0) begin bad++; $display("FAIL arst_tick got=%b want=0", tick); end
        total++; if (rd_count !== '0) begin bad++; $display("FAIL arst_rd got=%0d want=0", rd_count); end
        total++; if (busy !== 5'b11111) begin bad++; $display("FAIL arst_busy got=%b want=11111", busy); end
        arst = 1'b0;
        model_reset();
        for (int c = 1; c <= 22; c++) begin
            logic [CH-1:0] exp;
            tick_clk();
            exp = (c == 21) ? 5'b11111 : 5'b00000;
            total++;
            if (tick !== exp) begin bad++; $display("FAIL default_period c=%0d got=%b want=%b", c, tick, exp); end
            if (c == 10) begin
                total++;
                if (rd_count !== 8'd9) begin bad++; $display("FAIL arst_count got=%0d want=9", rd_count); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_pause();
        test_reload();
        test_period0();
        test_random();
        test_arst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
